// File: rtl/multicycle_control_if.sv
// Control/datapath bundle between the multi-cycle FSM and the IR/MDR/A/B/ALUOut datapath.
// The FSM side uses the master modport; the datapath (or a bench standing in for it) uses slave.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       br_cond;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] MemtoReg;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic [3:0] state;
  logic       illegal;
  logic       retire;

  modport master (
    input  opcode, mem_ready, br_cond,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
    output MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, state, illegal, retire
  );

  modport slave (
    output opcode, mem_ready, br_cond,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
    input  MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, state, illegal, retire
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV64 core: sequences fetch/decode/execute/memory/writeback
// and decodes the datapath strobes and mux selects from the registered state.
module multicycle_control (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR_ADDR = 4'd11,
    S_JALR_PC   = 4'd12,
    S_LUI       = 4'd13,
    S_TRAP      = 4'd14,
    S_UNUSED    = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_e state_q;
  state_e state_d;

  logic       pc_write_s;
  logic       pc_write_cond_s;
  logic       iord_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic [1:0] mem_to_reg_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic [1:0] pc_source_s;
  logic       illegal_s;
  logic       retire_s;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR_ADDR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALU_WB;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        // opcode[5] separates STORE (0100011) from LOAD (0000011).
        if (bus.opcode[5]) begin
          state_d = S_MEM_WRITE;
        end else begin
          state_d = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        if (bus.mem_ready) begin
          state_d = S_MEM_WB;
        end else begin
          state_d = S_MEM_READ;
        end
      end
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: begin
        if (bus.mem_ready) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEM_WRITE;
        end
      end
      S_EXEC_R:    state_d = S_ALU_WB;
      S_EXEC_I:    state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JAL:       state_d = S_FETCH;
      S_JALR_ADDR: state_d = S_JALR_PC;
      S_JALR_PC:   state_d = S_FETCH;
      S_LUI:       state_d = S_ALU_WB;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_TRAP;
    endcase
  end

  // Output decode; everything is held at zero while reset is asserted.
  always_comb begin
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    iord_s          = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    reg_write_s     = 1'b0;
    mem_to_reg_s    = 2'b00;
    alu_src_a_s     = 2'b00;
    alu_src_b_s     = 2'b00;
    alu_op_s        = 2'b00;
    pc_source_s     = 2'b00;
    illegal_s       = 1'b0;
    retire_s        = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read_s  = 1'b1;
          alu_src_b_s = 2'b01;
          ir_write_s  = bus.mem_ready;
          pc_write_s  = bus.mem_ready;
        end
        S_DECODE: begin
          // ALUOut = OldPC + imm, the branch/JAL target.
          alu_src_a_s = 2'b10;
          alu_src_b_s = 2'b10;
        end
        S_MEM_ADDR: begin
          alu_src_a_s = 2'b01;
          alu_src_b_s = 2'b10;
        end
        S_MEM_READ: begin
          mem_read_s = 1'b1;
          iord_s     = 1'b1;
        end
        S_MEM_WB: begin
          reg_write_s  = 1'b1;
          mem_to_reg_s = 2'b01;
          retire_s     = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write_s = 1'b1;
          iord_s      = 1'b1;
          retire_s    = bus.mem_ready;
        end
        S_EXEC_R: begin
          alu_src_a_s = 2'b01;
          alu_op_s    = 2'b10;
        end
        S_EXEC_I: begin
          alu_src_a_s = 2'b01;
          alu_src_b_s = 2'b10;
          alu_op_s    = 2'b11;
        end
        S_ALU_WB: begin
          reg_write_s = 1'b1;
          retire_s    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_s     = 2'b01;
          alu_op_s        = 2'b01;
          pc_write_cond_s = 1'b1;
          pc_source_s     = 2'b01;
          retire_s        = 1'b1;
        end
        S_JAL: begin
          reg_write_s  = 1'b1;
          mem_to_reg_s = 2'b10;
          pc_write_s   = 1'b1;
          pc_source_s  = 2'b01;
          retire_s     = 1'b1;
        end
        S_JALR_ADDR: begin
          alu_src_a_s = 2'b01;
          alu_src_b_s = 2'b10;
        end
        S_JALR_PC: begin
          reg_write_s  = 1'b1;
          mem_to_reg_s = 2'b10;
          pc_write_s   = 1'b1;
          pc_source_s  = 2'b10;
          retire_s     = 1'b1;
        end
        S_LUI: begin
          alu_src_a_s = 2'b11;
          alu_src_b_s = 2'b10;
        end
        S_TRAP: begin
          illegal_s = 1'b1;
        end
        default: begin
          illegal_s = 1'b0;
        end
      endcase
    end else begin
      illegal_s = 1'b0;
    end
  end

  assign bus.PCWrite     = pc_write_s;
  assign bus.PCWriteCond = pc_write_cond_s;
  assign bus.IorD        = iord_s;
  assign bus.MemRead     = mem_read_s;
  assign bus.MemWrite    = mem_write_s;
  assign bus.IRWrite     = ir_write_s;
  assign bus.RegWrite    = reg_write_s;
  assign bus.MemtoReg    = mem_to_reg_s;
  assign bus.ALUSrcA     = alu_src_a_s;
  assign bus.ALUSrcB     = alu_src_b_s;
  assign bus.ALUOp       = alu_op_s;
  assign bus.PCSource    = pc_source_s;
  assign bus.state       = state_q;
  assign bus.illegal     = illegal_s;
  assign bus.retire      = retire_s;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed per-cycle vector table, hand-written reset/trap
// sequences, and random instruction streams checked against an instruction-level model.
module tb_multicycle_control;

  logic clk;
  logic reset;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, rgw;
    logic [1:0] m2r, sa, sb, aop, pcs;
    logic       ill, ret;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       mr;
    logic       brc;
    logic [3:0] st;
    logic [6:0] strb;
    logic [1:0] m2r;
    logic [1:0] pcs;
    logic       ret;
  } vec_t;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    ret_seen = 0;
  int    ret_exp  = 0;
  vec_t  vecs[$];
  int    path[$];
  outs_t dut_o;

  assign dut_o = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                  bus.IRWrite, bus.RegWrite, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB,
                  bus.ALUOp, bus.PCSource, bus.illegal, bus.retire};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic cyc(input logic rst, input logic [6:0] op, input logic mr, input logic brc);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.opcode    = op;
    bus.mem_ready = mr;
    bus.br_cond   = brc;
    @(negedge clk);
  endtask

  function automatic vec_t mk(logic rst, logic [6:0] op, logic mr, logic brc, logic [3:0] st,
                              logic [6:0] strb, logic [1:0] m2r, logic [1:0] pcs, logic ret);
    vec_t v;
    v.rst = rst; v.op = op; v.mr = mr; v.brc = brc; v.st = st;
    v.strb = strb; v.m2r = m2r; v.pcs = pcs; v.ret = ret;
    return v;
  endfunction

  // Expected outputs for a state, straight from the state table.
  function automatic outs_t ref_outs(int st, logic mr, logic rst);
    outs_t o;
    o = '0;
    if (!rst) begin
      case (st)
        0:  begin o.mrd = 1'b1; o.sb = 2'b01; o.irw = mr; o.pcw = mr; end
        1:  begin o.sa = 2'b10; o.sb = 2'b10; end
        2:  begin o.sa = 2'b01; o.sb = 2'b10; end
        3:  begin o.mrd = 1'b1; o.iord = 1'b1; end
        4:  begin o.rgw = 1'b1; o.m2r = 2'b01; o.ret = 1'b1; end
        5:  begin o.mwr = 1'b1; o.iord = 1'b1; o.ret = mr; end
        6:  begin o.sa = 2'b01; o.sb = 2'b00; o.aop = 2'b10; end
        7:  begin o.sa = 2'b01; o.sb = 2'b10; o.aop = 2'b11; end
        8:  begin o.rgw = 1'b1; o.ret = 1'b1; end
        9:  begin o.sa = 2'b01; o.aop = 2'b01; o.pcwc = 1'b1; o.pcs = 2'b01; o.ret = 1'b1; end
        10: begin o.rgw = 1'b1; o.m2r = 2'b10; o.pcw = 1'b1; o.pcs = 2'b01; o.ret = 1'b1; end
        11: begin o.sa = 2'b01; o.sb = 2'b10; end
        12: begin o.rgw = 1'b1; o.m2r = 2'b10; o.pcw = 1'b1; o.pcs = 2'b10; o.ret = 1'b1; end
        13: begin o.sa = 2'b11; o.sb = 2'b10; end
        14: begin o.ill = 1'b1; end
        default: o = '0;
      endcase
    end
    return o;
  endfunction

  // Instruction-level model: the sequence of steps an opcode walks through.
  task automatic build_path(input logic [6:0] op);
    path.delete();
    path.push_back(0);
    path.push_back(1);
    case (op)
      7'h03: begin path.push_back(2); path.push_back(3); path.push_back(4); end
      7'h23: begin path.push_back(2); path.push_back(5); end
      7'h33: begin path.push_back(6); path.push_back(8); end
      7'h13: begin path.push_back(7); path.push_back(8); end
      7'h63: path.push_back(9);
      7'h6F: path.push_back(10);
      7'h67: begin path.push_back(11); path.push_back(12); end
      7'h37: begin path.push_back(13); path.push_back(8); end
      7'h17: path.push_back(8);
      default: path.push_back(14);
    endcase
  endtask

  task automatic chk_step(input string name, input int st, input logic mr, input logic rst);
    outs_t e;
    e = ref_outs(st, mr, rst);
    chk({name, ".state"}, 32'(bus.state), 32'(st));
    chk({name, ".outs"}, 32'(dut_o), 32'(e));
    ret_seen += int'(bus.retire);
  endtask

  localparam logic [6:0] S_FR = 7'b1001010;
  localparam logic [6:0] S_FW = 7'b0001000;
  localparam logic [6:0] S_RD = 7'b0011000;
  localparam logic [6:0] S_WR = 7'b0010100;
  localparam logic [6:0] S_RG = 7'b0000001;
  localparam logic [6:0] S_BR = 7'b0100000;
  localparam logic [6:0] S_JP = 7'b1000001;
  localparam logic [6:0] S_NO = 7'b0000000;

  logic [6:0] legal_ops [9];

  initial begin
    reset = 1'b1;
    bus.opcode = 7'h00;
    bus.mem_ready = 1'b0;
    bus.br_cond = 1'b0;
    legal_ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    // rst, op, mr, brc, state, strobes{pcw,pcwc,iord,mrd,mwr,irw,rgw}, m2r, pcs, ret
    vecs.push_back(mk(1'b1, 7'h33, 1'b1, 1'b0, 4'd0,  S_NO, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h33, 1'b0, 1'b0, 4'd0,  S_FW, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h33, 1'b1, 1'b0, 4'd0,  S_FR, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h33, 1'b1, 1'b0, 4'd1,  S_NO, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h33, 1'b1, 1'b0, 4'd6,  S_NO, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h33, 1'b1, 1'b0, 4'd8,  S_RG, 2'b00, 2'b00, 1'b1));
    vecs.push_back(mk(1'b0, 7'h03, 1'b1, 1'b0, 4'd0,  S_FR, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h03, 1'b1, 1'b0, 4'd1,  S_NO, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h03, 1'b1, 1'b0, 4'd2,  S_NO, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h03, 1'b0, 1'b0, 4'd3,  S_RD, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h03, 1'b0, 1'b0, 4'd3,  S_RD, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h03, 1'b1, 1'b0, 4'd3,  S_RD, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h03, 1'b0, 1'b0, 4'd4,  S_RG, 2'b01, 2'b00, 1'b1));
    vecs.push_back(mk(1'b0, 7'h63, 1'b1, 1'b1, 4'd0,  S_FR, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h63, 1'b1, 1'b1, 4'd1,  S_NO, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h63, 1'b1, 1'b1, 4'd9,  S_BR, 2'b00, 2'b01, 1'b1));
    vecs.push_back(mk(1'b0, 7'h63, 1'b1, 1'b0, 4'd0,  S_FR, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h63, 1'b1, 1'b0, 4'd1,  S_NO, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h63, 1'b1, 1'b0, 4'd9,  S_BR, 2'b00, 2'b01, 1'b1));
    vecs.push_back(mk(1'b0, 7'h67, 1'b1, 1'b0, 4'd0,  S_FR, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h67, 1'b1, 1'b0, 4'd1,  S_NO, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h67, 1'b1, 1'b0, 4'd11, S_NO, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h67, 1'b1, 1'b0, 4'd12, S_JP, 2'b10, 2'b10, 1'b1));
    vecs.push_back(mk(1'b0, 7'h6F, 1'b1, 1'b0, 4'd0,  S_FR, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h6F, 1'b1, 1'b0, 4'd1,  S_NO, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h6F, 1'b1, 1'b0, 4'd10, S_JP, 2'b10, 2'b01, 1'b1));
    vecs.push_back(mk(1'b0, 7'h17, 1'b1, 1'b0, 4'd0,  S_FR, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h17, 1'b1, 1'b0, 4'd1,  S_NO, 2'b00, 2'b00, 1'b0));
    vecs.push_back(mk(1'b0, 7'h17, 1'b1, 1'b0, 4'd8,  S_RG, 2'b00, 2'b00, 1'b1));

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].op, vecs[i].mr, vecs[i].brc);
      chk($sformatf("vec%0d.state", i), 32'(bus.state), 32'(vecs[i].st));
      chk($sformatf("vec%0d.strobes", i),
          32'({bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
               bus.IRWrite, bus.RegWrite}), 32'(vecs[i].strb));
      chk($sformatf("vec%0d.m2r_pcs_ret", i),
          32'({bus.MemtoReg, bus.PCSource, bus.retire}),
          32'({vecs[i].m2r, vecs[i].pcs, vecs[i].ret}));
    end

    // Illegal opcode: TRAP holds with no strobes until reset.
    cyc(1'b0, 7'h7F, 1'b1, 1'b0);
    chk_step("trap.fetch", 0, 1'b1, 1'b0);
    cyc(1'b0, 7'h7F, 1'b1, 1'b0);
    chk_step("trap.decode", 1, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 7'h7F, 1'(k % 2), 1'(k % 3 == 0));
      chk_step($sformatf("trap.hold%0d", k), 14, 1'(k % 2), 1'b0);
    end
    cyc(1'b1, 7'h7F, 1'b0, 1'b0);
    chk_step("trap.reset", 0, 1'b0, 1'b1);
    cyc(1'b0, 7'h23, 1'b1, 1'b0);
    chk_step("trap.refetch", 0, 1'b1, 1'b0);

    // Store stalled on memory, then reset arrives mid-wait.
    cyc(1'b0, 7'h23, 1'b1, 1'b0);
    chk_step("st.decode", 1, 1'b1, 1'b0);
    cyc(1'b0, 7'h23, 1'b0, 1'b0);
    chk_step("st.addr", 2, 1'b0, 1'b0);
    cyc(1'b0, 7'h23, 1'b0, 1'b0);
    chk_step("st.wait0", 5, 1'b0, 1'b0);
    cyc(1'b0, 7'h23, 1'b0, 1'b0);
    chk_step("st.wait1", 5, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    chk("st.rst.memwrite", 32'(bus.MemWrite), 32'd0);
    chk("st.rst.retire", 32'(bus.retire), 32'd0);
    chk("st.rst.state", 32'(bus.state), 32'd0);
    cyc(1'b0, 7'h33, 1'b0, 1'b0);
    chk_step("st.resume", 0, 1'b0, 1'b0);

    // Random instruction stream against the instruction-level model.
    ret_seen = 0;
    ret_exp  = 0;
    for (int n = 0; n < 250; n++) begin
      logic [6:0] op;
      logic       brc;
      brc = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 5) op = 7'($urandom);
      else op = legal_ops[$urandom_range(0, 8)];
      build_path(op);
      foreach (path[j]) begin
        int st;
        logic mr;
        st = path[j];
        if (st == 0 || st == 3 || st == 5) begin
          int waits;
          waits = 0;
          do begin
            mr = ($urandom_range(0, 99) < 55 || waits >= 6) ? 1'b1 : 1'b0;
            cyc(1'b0, op, mr, brc);
            chk_step($sformatf("rnd%0d.s%0d", n, st), st, mr, 1'b0);
            waits++;
          end while (!mr);
        end else begin
          mr = 1'($urandom_range(0, 1));
          cyc(1'b0, op, mr, brc);
          chk_step($sformatf("rnd%0d.s%0d", n, st), st, mr, 1'b0);
        end
      end
      if (path[path.size() - 1] == 14) begin
        for (int k = 0; k < 2; k++) begin
          cyc(1'b0, op, 1'b1, brc);
          chk_step($sformatf("rnd%0d.trap", n), 14, 1'b1, 1'b0);
        end
        cyc(1'b1, op, 1'b0, brc);
        chk_step($sformatf("rnd%0d.rst", n), 0, 1'b0, 1'b1);
      end else begin
        ret_exp++;
      end
    end
    chk("rnd.retire_count", 32'(ret_seen), 32'(ret_exp));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle RV64 core. Sequences fetch/decode/execute/memory/writeback, drives the datapath enables and muxes around the IR/MDR/A/B/ALUOut register bank, and handshakes with a single shared memory port via `mem_ready`. It is fed the opcode from the instruction register and drives `IRWrite` back into it.

## Interface
- No parameters.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `opcode`  in  7  `IR[6:0]`.
- `mem_ready`  in  1  memory access complete. Read data is valid in the same cycle.
- `br_cond`  in  1  datapath comparator result for `IR.funct3` on A/B.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `RegWrite`  out  1 each  datapath strobes.
- `MemtoReg`  out  2  register writeback source: 00 ALUOut, 01 MDR, 10 PC.
- `ALUSrcA`  out  2  ALU A input: 00 PC, 01 A, 10 OldPC, 11 zero.
- `ALUSrcB`  out  2  ALU B input: 00 B, 01 const 4, 10 imm.
- `ALUOp`  out  2  ALU operation: 00 add, 01 compare/sub, 10 R-decode, 11 I-decode.
- `PCSource`  out  2  PC source: 00 ALU result, 01 ALUOut, 10 ALUOut with bit0 cleared.
- `state`  out  4  current state, for debug.
- `illegal`  out  1  high while in TRAP.
- `retire`  out  1  one-cycle pulse in the final cycle of each instruction.

## Operation
State encodings (defaults not listed below are 0):
- 0 FETCH: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00. IRWrite and PCWrite are each asserted equal to `mem_ready`. The datapath latches OldPC on IRWrite. Next state is DECODE if `mem_ready`, else FETCH.
- 1 DECODE: ALUSrcA=10, ALUSrcB=10, ALUOp=00, so ALUOut = OldPC+imm. Next state by opcode:
  - 0000011 or 0100011 → MEM_ADDR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR_ADDR
  - 0110111 → LUI
  - 0010111 (AUIPC) → ALU_WB
  - any other opcode → TRAP
- 2 MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Next state is MEM_READ if `opcode[5]`=0, else MEM_WRITE.
- 3 MEM_READ: MemRead=1, IorD=1. Stays until `mem_ready`, then MEM_WB.
- 4 MEM_WB: RegWrite=1, MemtoReg=01, retire. Next state FETCH.
- 5 MEM_WRITE: MemWrite=1, IorD=1. Stays until `mem_ready`; `retire` is asserted in the cycle `mem_ready` is seen, then FETCH.
- 6 EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUOp=10. Next state ALU_WB.
- 7 EXEC_I: ALUSrcA=01, ALUSrcB=10, ALUOp=11. Next state ALU_WB.
- 8 ALU_WB: RegWrite=1, MemtoReg=00, retire. Next state FETCH.
- 9 BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, retire. The datapath loads PC when `PCWriteCond & br_cond`. Next state FETCH.
- 10 JAL: RegWrite=1, MemtoReg=10 (PC already holds PC+4), PCWrite=1, PCSource=01, retire. Next state FETCH.
- 11 JALR_ADDR: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Next state JALR_PC.
- 12 JALR_PC: RegWrite=1, MemtoReg=10, PCWrite=1, PCSource=10, retire. Next state FETCH.
- 13 LUI: ALUSrcA=11, ALUSrcB=10, ALUOp=00. Next state ALU_WB.
- 14 TRAP: all strobes 0, illegal=1. Stays in TRAP until reset.
- Encoding 15 is unreachable. If entered, the FSM goes to TRAP next cycle.

## Timing
- All outputs are decoded from registered `state`. Only IRWrite, PCWrite and `retire` in FETCH/MEM_WRITE also depend combinationally on `mem_ready`.
- Reset: `state`=0 (FETCH) immediately. While `reset` is high, all strobes, `illegal` and `retire` are forced to 0; mux selects are 0. The first fetch request occurs in the first cycle after `reset` falls.
- Reset during a memory wait drops MemRead/MemWrite in the same cycle (asynchronous), with no completion and no retire.
- Memory requests hold MemRead/MemWrite and IorD stable until the `mem_ready` cycle inclusive. `mem_ready` outside FETCH/MEM_READ/MEM_WRITE is ignored.
- Latency with `mem_ready` tied high:
  - load 5 cycles
  - store, R-type, I-type, JALR, LUI: 4 cycles
  - branch, JAL, AUIPC: 3 cycles
- Each wait cycle adds 1 cycle.
- Exactly one `retire` pulse per completed instruction. TRAP never retires.

## Test plan
- R-type add (`opcode`=0110011), `mem_ready`=1 → states 0,1,6,8,0; RegWrite and retire only in the cycle of state 8; IRWrite=PCWrite=1 in the cycle of state 0.
- Load with fetch ready and 2 read wait states → states 0,1,2,3,3,3,4; MemRead=1 and IorD=1 held across all three state-3 cycles; MemtoReg=01 in state 4.
- Branch, first with `br_cond`=1, then with `br_cond`=0 → both runs go 0,1,9 with PCWriteCond=1 and PCSource=01; PCWrite stays 0 throughout both runs; retire in state 9 both times.
- JALR → PCSource=10 and MemtoReg=10 in state 12; JAL → PCSource=01 in state 10; AUIPC → states 0,1,8.
- Illegal `opcode`=1111111 → TRAP with illegal=1; no strobes for 10 cycles; reset pulse → FETCH and illegal=0.
- Store with `mem_ready` low, then reset asserted in state 5 → MemWrite=0 the same cycle, no retire; after reset release FETCH resumes with MemRead=1.
